// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency unified memory between the
//   instruction-fetch port (IF) and the data port (MEM stage). Each access
//   occupies a window of LAT cycles. When both ports compete, the port that
//   was not granted last wins (round-robin). The next grant is decided in
//   the ack cycle, so back-to-back accesses leave no idle gap. A saturating
//   counter records the IF cycles lost to data-port contention.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req/if_addr           fetch request; held until if_ack
//   if_rdata/if_ack          fetch data and one-cycle completion pulse
//   stall_if                 if_req & ~if_ack
//   d_req/d_we/d_addr/d_wdata  data request; held until d_ack
//   d_rdata/d_ack            read data (0 on writes) and completion pulse
//   stall_d                  d_req & ~d_ack
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory controls for the window
//   mem_rdata                memory read data, valid in the last window cycle
//   conflict_cnt             saturating contention counter
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT    = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              stall_if,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              stall_d,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arbStateT;

  localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

  arbStateT   state;
  logic [3:0] cnt;
  logic       lastGrant;   // 0 = IF, 1 = D

  logic ackCycle;
  logic ifElig;
  logic dElig;
  logic decide;
  logic grantD;
  logic grantI;
  logic conflictHit;

  always_comb begin
    ackCycle = (state != IDLE) && (cnt == LAST_CNT);
    if_ack   = ackCycle && (state == BUSY_I);
    d_ack    = ackCycle && (state == BUSY_D);

    if_rdata = if_ack ? mem_rdata : '0;
    d_rdata  = (d_ack && !mem_we) ? mem_rdata : '0;

    stall_if = if_req & ~if_ack;
    stall_d  = d_req & ~d_ack;

    // The port being acked this cycle may still show req high; it must not
    // be re-granted on the strength of that stale request.
    ifElig = if_req && !if_ack;
    dElig  = d_req && !d_ack;

    decide = (state == IDLE) || ackCycle;

    // With both eligible, D wins unless D was granted last.
    grantD = decide && dElig && (!ifElig || !lastGrant);
    grantI = decide && ifElig && !grantD;

    conflictHit = (if_req && (state == BUSY_D)) ||
                  ((state == IDLE) && ifElig && dElig && grantD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lastGrant    <= 1'b0;
      conflict_cnt <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      if (conflictHit && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end

      if (grantD) begin
        state     <= BUSY_D;
        cnt       <= '0;
        lastGrant <= 1'b1;
        mem_en    <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grantI) begin
        state     <= BUSY_I;
        cnt       <= '0;
        lastGrant <= 1'b0;
        mem_en    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
      end else if (decide) begin
        // Idle with nothing to do, or an ack cycle with no follow-on request.
        state  <= IDLE;
        cnt    <= '0;
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (LAT=2, CNT_W=4). A behavioural
//   memory answers every window: unwritten words read as a fixed pattern
//   of their address (word 5 holds 32'h2002000A), written words read back
//   what was stored.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [6:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        stall_if;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [6:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall_d;
  logic        mem_en;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(7),
    .DATA_W(32),
    .LAT(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ack(if_ack),
    .stall_if(stall_if),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ack(d_ack),
    .stall_d(stall_d),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  // Memory model
  logic [31:0]  memArr [128];
  logic [127:0] memWritten = '0;

  function automatic logic [31:0] defaultWord(input logic [6:0] a);
    if (a == 7'h05) return 32'h2002000A;
    return 32'hA5000000 | {25'd0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      memArr[mem_addr]     <= mem_wdata;
      memWritten[mem_addr] <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_en) begin
      mem_rdata = memWritten[mem_addr] ? memArr[mem_addr] : defaultWord(mem_addr);
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    nextCycle();
    rst = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    nextCycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      if_req  = 1'($urandom);
      if_addr = 7'($urandom);
      d_req   = 1'($urandom);
      d_we    = 1'($urandom);
      d_addr  = 7'($urandom);
      d_wdata = $urandom;
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, conflict_cnt} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h iack=%b dack=%b ird=%h drd=%h cc=%h, required all 0",
                 mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, conflict_cnt);
      end
      checks++;
      if ({stall_if, stall_d} !== {if_req, d_req}) begin
        errors++;
        $display("FAIL reset_stall: got %b%b required %b%b", stall_if, stall_d, if_req, d_req);
      end
    end
    nextCycle();
    if_req = 1'b0;
    d_req  = 1'b0;
    d_we   = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      #1;
      checks++;
      if ({mem_en, if_ack, d_ack, conflict_cnt} !== 7'd0) begin
        errors++;
        $display("FAIL idle_after_reset: got en=%b iack=%b dack=%b cc=%h, required 0", mem_en, if_ack, d_ack, conflict_cnt);
      end
    end
  endtask

  task automatic test_single_fetch();
    nextCycle();
    if_req  = 1'b1;
    if_addr = 7'h05;
    #1;
    checks++;
    if ({stall_if, mem_en, if_ack} !== 3'b100) begin
      errors++;
      $display("FAIL fetch_c0: got stall=%b en=%b ack=%b required 1 0 0", stall_if, mem_en, if_ack);
    end
    nextCycle();
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, if_ack, stall_if} !== {2'b10, 7'h05, 2'b01}) begin
      errors++;
      $display("FAIL fetch_c1: got en=%b we=%b addr=%h ack=%b stall=%b required 1 0 05 0 1",
               mem_en, mem_we, mem_addr, if_ack, stall_if);
    end
    nextCycle();
    #1;
    checks++;
    if ({mem_en, mem_addr, if_ack, stall_if} !== {1'b1, 7'h05, 2'b10}) begin
      errors++;
      $display("FAIL fetch_c2: got en=%b addr=%h ack=%b stall=%b required 1 05 1 0", mem_en, mem_addr, if_ack, stall_if);
    end
    checks++;
    if (if_rdata !== 32'h2002000A) begin
      errors++;
      $display("FAIL fetch_rdata: got %h required 2002000a", if_rdata);
    end
    if_req = 1'b0;
    nextCycle();
    #1;
    checks++;
    if ({mem_en, if_ack, if_rdata} !== 34'd0) begin
      errors++;
      $display("FAIL fetch_c3: got en=%b ack=%b rdata=%h required 0", mem_en, if_ack, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    bit [5:0]   expEn    = 6'b011110;
    bit [5:0]   expDAck  = 6'b000100;
    bit [5:0]   expIfAck = 6'b010000;
    logic [6:0] expAddr;
    logic [3:0] expCnt;
    doReset();
    for (int c = 0; c < 6; c++) begin
      nextCycle();
      if (c == 0) begin
        if_req  = 1'b1;
        if_addr = 7'h21;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 7'h10;
      end
      #1;
      expAddr = (c <= 2) ? 7'h10 : 7'h21;
      expCnt  = 4'((c > 3) ? 3 : c);
      checks++;
      if (mem_en !== expEn[c]) begin
        errors++;
        $display("FAIL simul_en c%0d: got %b required %b", c, mem_en, expEn[c]);
      end
      if (expEn[c]) begin
        checks++;
        if (mem_addr !== expAddr) begin
          errors++;
          $display("FAIL simul_addr c%0d: got %h required %h", c, mem_addr, expAddr);
        end
      end
      checks++;
      if ({if_ack, d_ack} !== {expIfAck[c], expDAck[c]}) begin
        errors++;
        $display("FAIL simul_acks c%0d: got if=%b d=%b required if=%b d=%b", c, if_ack, d_ack, expIfAck[c], expDAck[c]);
      end
      checks++;
      if ({if_rdata, d_rdata} !== {(expIfAck[c] ? 32'hA5000021 : 32'h0), (expDAck[c] ? 32'hA5000010 : 32'h0)}) begin
        errors++;
        $display("FAIL simul_rdata c%0d: got if=%h d=%h", c, if_rdata, d_rdata);
      end
      checks++;
      if (conflict_cnt !== expCnt) begin
        errors++;
        $display("FAIL simul_conflict c%0d: got %0d required %0d", c, conflict_cnt, expCnt);
      end
      if (c == 2) d_req = 1'b0;
      if (c == 4) if_req = 1'b0;
    end
  endtask

  task automatic test_continuous();
    logic [3:0] expCnt = '0;
    logic       isD;
    logic       expEn;
    logic       expAck;
    doReset();
    for (int c = 0; c < 14; c++) begin
      nextCycle();
      if (c == 0) begin
        if_req  = 1'b1;
        if_addr = 7'h05;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 7'h10;
      end
      #1;
      expEn  = (c >= 1) && (c <= 12);
      isD    = expEn && ((((c - 1) / 2) % 2) == 0);
      expAck = (c >= 2) && (c <= 12) && ((c % 2) == 0);
      checks++;
      if (mem_en !== expEn) begin
        errors++;
        $display("FAIL cont_en c%0d: got %b required %b", c, mem_en, expEn);
      end
      if (expEn) begin
        checks++;
        if ({mem_addr, mem_we} !== {(isD ? 7'h10 : 7'h05), 1'b0}) begin
          errors++;
          $display("FAIL cont_grant c%0d: got addr=%h we=%b required addr=%h we=0", c, mem_addr, mem_we, isD ? 7'h10 : 7'h05);
        end
      end
      checks++;
      if ({d_ack, if_ack} !== {expAck && isD, expAck && !isD}) begin
        errors++;
        $display("FAIL cont_acks c%0d: got d=%b if=%b required d=%b if=%b", c, d_ack, if_ack, expAck && isD, expAck && !isD);
      end
      checks++;
      if ({d_rdata, if_rdata} !== {((expAck && isD) ? 32'hA5000010 : 32'h0), ((expAck && !isD) ? 32'h2002000A : 32'h0)}) begin
        errors++;
        $display("FAIL cont_rdata c%0d: got d=%h if=%h", c, d_rdata, if_rdata);
      end
      checks++;
      if (conflict_cnt !== expCnt) begin
        errors++;
        $display("FAIL cont_conflict c%0d: got %0d required %0d", c, conflict_cnt, expCnt);
      end
      if (((c == 0) || (isD && (c <= 11))) && (expCnt != 4'hF)) expCnt = expCnt + 4'd1;
      if (c == 11) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
  endtask

  task automatic test_write_read();
    doReset();
    nextCycle();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 7'h10;
    d_wdata = 32'hDEADBEEF;
    nextCycle();
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, d_ack, stall_d} !== {2'b11, 7'h10, 32'hDEADBEEF, 2'b01}) begin
      errors++;
      $display("FAIL write_c1: got en=%b we=%b addr=%h wd=%h ack=%b stall=%b required 1 1 10 deadbeef 0 1",
               mem_en, mem_we, mem_addr, mem_wdata, d_ack, stall_d);
    end
    // Requester misbehaves mid-window; the window must not notice.
    d_addr  = 7'h11;
    d_wdata = 32'h12345678;
    nextCycle();
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, d_ack, stall_d} !== {1'b1, 7'h10, 32'hDEADBEEF, 2'b10}) begin
      errors++;
      $display("FAIL write_c2: got we=%b addr=%h wd=%h ack=%b stall=%b required 1 10 deadbeef 1 0",
               mem_we, mem_addr, mem_wdata, d_ack, stall_d);
    end
    checks++;
    if (d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_rdata: got %h required 0", d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    nextCycle();
    #1;
    checks++;
    if ({mem_en, mem_we} !== 2'b00) begin
      errors++;
      $display("FAIL write_c3: got en=%b we=%b required 0 0", mem_en, mem_we);
    end
    d_req  = 1'b1;
    d_addr = 7'h10;
    nextCycle();
    #1;
    checks++;
    if ({mem_en, mem_we, d_ack} !== 3'b100) begin
      errors++;
      $display("FAIL read_c1: got en=%b we=%b ack=%b required 1 0 0", mem_en, mem_we, d_ack);
    end
    nextCycle();
    #1;
    checks++;
    if ({d_ack, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL read_back: got ack=%b rdata=%h required 1 deadbeef", d_ack, d_rdata);
    end
    d_req = 1'b0;
    nextCycle();
  endtask

  task automatic test_reset_mid();
    doReset();
    nextCycle();
    if_req  = 1'b1;
    if_addr = 7'h05;
    nextCycle();
    #1;
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got en=%b required 1", mem_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_en, if_ack, mem_addr} !== 9'd0) begin
      errors++;
      $display("FAIL midrst_async: got en=%b ack=%b addr=%h required 0", mem_en, if_ack, mem_addr);
    end
    nextCycle();
    #1;
    checks++;
    if ({mem_en, if_ack} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_noack: got en=%b ack=%b required 0 0", mem_en, if_ack);
    end
    rst = 1'b1;
    nextCycle();
    #1;
    checks++;
    if ({mem_en, mem_addr, if_ack} !== {1'b1, 7'h05, 1'b0}) begin
      errors++;
      $display("FAIL midrst_regrant: got en=%b addr=%h ack=%b required 1 05 0", mem_en, mem_addr, if_ack);
    end
    nextCycle();
    #1;
    checks++;
    if ({if_ack, if_rdata} !== {1'b1, 32'h2002000A}) begin
      errors++;
      $display("FAIL midrst_ack: got ack=%b rdata=%h required 1 2002000a", if_ack, if_rdata);
    end
    if_req = 1'b0;
    nextCycle();
  endtask

  task automatic test_saturation();
    logic [3:0] expCnt = '0;
    logic       isD;
    doReset();
    for (int c = 0; c < 48; c++) begin
      nextCycle();
      if (c == 0) begin
        if_req  = 1'b1;
        if_addr = 7'h05;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 7'h10;
      end
      #1;
      isD = (c >= 1) && ((((c - 1) / 2) % 2) == 0);
      checks++;
      if (conflict_cnt !== expCnt) begin
        errors++;
        $display("FAIL sat_cnt c%0d: got %0d required %0d", c, conflict_cnt, expCnt);
      end
      if (((c == 0) || isD) && (expCnt != 4'hF)) expCnt = expCnt + 4'd1;
    end
    nextCycle();
    #1;
    checks++;
    if (conflict_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_final: got %h required f", conflict_cnt);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 4; i++) nextCycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_continuous();
    test_write_read();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage).
- Sequences each access over LAT cycles and drives per-port stall signals into the pipeline bubble/hold logic.
- Keeps a saturating count of IF cycles lost to data-port contention.

Parameters:
ADDR_W, 7, word address width (matches the 7-bit IM/DM word index)
DATA_W, 32, data width
LAT, 2, cycles the memory needs per access; legal range 1..15
CNT_W, 16, width of the contention counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch word address
if_rdata  out  DATA_W  fetch data, valid only while if_ack=1
if_ack  out  1  one-cycle completion pulse for fetch
stall_if  out  1  if_req & ~if_ack
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid only while d_ack=1
d_ack  out  1  one-cycle completion pulse for data
stall_d  out  1  d_req & ~d_ack
mem_en  out  1  memory access window active
mem_we  out  1  write enable for the whole window
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, valid in the last cycle of the window
conflict_cnt  out  CNT_W  saturating contention counter

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. Registers: 4-bit cnt, last_grant (0 = IF, 1 = D).
- Reset while rst=0, asynchronous, including mid-access:
  - State=IDLE, cnt=0, last_grant=0, conflict_cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Both acks=0, both rdata=0.
  - An in-flight access is abandoned with no ack.
- Grant decision is made in IDLE, or in a BUSY ack cycle for back-to-back operation.
  - Only one eligible request: grant it.
  - Both eligible: grant the port not equal to last_grant (round-robin). After reset the first conflict goes to D.
  - In an ack cycle the acked port is ineligible, even if its req is still high.
- Grant at edge N:
  - Next state is BUSY_x; cnt=0; last_grant updates.
  - mem_en=1 and mem_addr latches the winner's address; for D, also mem_we=d_we and mem_wdata=d_wdata.
  - For IF, mem_we=0.
- BUSY_x:
  - cnt increments each cycle.
  - When cnt==LAT-1, the ack cycle: x_ack=1 combinationally, and x_rdata=mem_rdata (0 on a write).
  - At the following edge: grant the next eligible port per the rules above, else go to IDLE with mem_en=0 and mem_we=0.
- Latency and throughput:
  - Uncontended request to ack: LAT cycles after the grant edge, i.e. the ack falls in cycle LAT when req is raised in cycle 0.
  - Sustained throughput: one access per LAT cycles with no idle gap.
- mem_addr, mem_we and mem_wdata are stable for the whole window. Requester changes mid-window are ignored.
- A requester dropping req before ack: the access still completes and the ack still pulses.
- conflict_cnt increments by 1 in any cycle where:
  - if_req=1 and state=BUSY_D, or
  - state=IDLE and both requests are eligible and D wins.
- conflict_cnt saturates at all-ones.
- Outside ack cycles, if_rdata and d_rdata are 0.

Test Plan:
LAT=2 in all scenarios; the memory model returns the stored word in the last window cycle.
1. Reset: rst=0 with random inputs -> all outputs 0. Release, no requests -> mem_en stays 0.
2. Single fetch: if_req=1, if_addr=7'h05 at cycle 0 (mem[5]=32'h2002000A) -> mem_en=1 with mem_addr=05 in cycles 1-2; if_ack=1 and if_rdata=32'h2002000A in cycle 2; stall_if=1 in cycles 0-1.
3. Simultaneous request after reset: if_req and d_req (read, addr 7'h10) at cycle 0 ->
   - D window in cycles 1-2, d_ack in cycle 2.
   - IF window in cycles 3-4 with no gap, if_ack in cycle 4.
   - conflict_cnt=3.
4. Continuous contention: both reqs held high for 12 cycles -> grants alternate D, I, D, I; acks in cycles 2, 4, 6, 8, ...; mem_en never drops.
5. Write then read: d_we=1, d_addr=7'h10, d_wdata=32'hDEADBEEF -> mem_we=1 in cycles 1-2, d_ack in cycle 2, d_rdata=0. A subsequent read of 10 -> d_rdata=32'hDEADBEEF.
6. Reset mid-access: if_req at cycle 0, rst=0 during cycle 1 ->
   - mem_en drops immediately; no if_ack.
   - After release with if_req still high: a new grant, and if_ack 2 cycles after the grant edge.
7. Saturation: force conflict for 2^CNT_W+5 cycles (CNT_W=4 build) -> conflict_cnt holds at 4'hF.
